// File: rtl/mx_quant_stream_if.sv
// Stream bundle for mx_quant_stream: sample input channel plus element/scale output channel.
// slave is the quantizer's view; master is the environment that supplies samples and consumes elements.
// Widths follow the quantizer parameters; both sides must instantiate with matching values.
interface mx_quant_stream_if #(
    parameter int in_width  = 24,
    parameter int exp_width = 4,
    parameter int man_width = 3,
    parameter int scl_width = 8
);
    logic [in_width-1:0]            i_data;
    logic                           i_data_valid;
    logic                           o_data_ready;
    logic [exp_width+man_width:0]   o_elem;
    logic [scl_width-1:0]           o_scale;
    logic                           o_elem_valid;
    logic                           o_last;
    logic                           i_elem_ready;

    modport slave (
        input  i_data, i_data_valid, i_elem_ready,
        output o_data_ready, o_elem, o_scale, o_elem_valid, o_last
    );

    modport master (
        output i_data, i_data_valid, i_elem_ready,
        input  o_data_ready, o_elem, o_scale, o_elem_valid, o_last
    );
endinterface

// File: rtl/mx_quant_stream.sv
// Streaming MX block quantizer: buffers k samples, derives a shared power-of-two scale, emits k {s,e,m} elements.
// Latency: last sample accepted on edge T, one CALC cycle, first element presented from edge T+1 (consumable at T+2).
// Backpressure: samples accepted only in FILL; elements hold stable while i_elem_ready is low. MX_QUANT_RNE_EN selects RNE rounding (else truncate).
module mx_quant_stream #(
    parameter int in_width  = 24,
    parameter int exp_width = 4,
    parameter int man_width = 3,
    parameter int k         = 32,
    parameter int scl_width = 8
) (
    input  logic             clk,
    input  logic             rst,
    mx_quant_stream_if.slave bus
);
    // Width of the largest element magnitude; the scale lifts the block maximum into this range.
    localparam int W  = man_width + 2**exp_width - 1;
    localparam int CW = (k > 1) ? $clog2(k) : 1;
    localparam int EW = 1 + exp_width + man_width;
    // Intermediate magnitude width: rounding carry plus one spare bit.
    localparam int MW = in_width + 2;

    localparam logic [CW-1:0] LAST_IDX = CW'(k - 1);
    localparam logic [MW-1:0] MAX_M    = MW'(((2**(man_width + 1)) - 1) * (2**(2**exp_width - 2)));

    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    generate
        if (in_width - W >= 2**scl_width) begin : g_scale_range
            $error("mx_quant_stream: scl_width too narrow for the largest possible scale");
        end
    endgenerate

    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          idx;
    logic [in_width-1:0]    max_abs;
    logic [in_width-1:0]    buffer [0:k-1];

    logic [EW-1:0]          cur_elem;
    logic [scl_width-1:0]   cur_scale;
    logic                   cur_valid;
    logic                   cur_last;

    int                     max_msb;
    logic [scl_width-1:0]   scale_calc;
    logic [CW-1:0]          sel;
    logic [scl_width-1:0]   use_scale;
    logic [in_width-1:0]    sample;
    logic [in_width-1:0]    in_mag;
    logic [in_width-1:0]    sample_mag;
    logic [EW-2:0]          em;
    logic [EW-1:0]          next_elem;

    function automatic int msb_pos(input logic [MW-1:0] x);
        int r;
        r = 0;
        for (int i = 0; i < MW; i++) begin
            if (x[i]) r = i;
        end
        return r;
    endfunction

    // Two's-complement magnitude; the most negative input maps to 2**(in_width-1) unsigned.
    function automatic logic [in_width-1:0] abs_val(input logic [in_width-1:0] v);
        return v[in_width-1] ? (~v + 1'b1) : v;
    endfunction

    // Map |v| / 2**s onto the {e,m} grid. The grid step at t's magnitude is
    // 2**max(0, msb(t)-man_width), so in |v| units the quantum sits at bit g.
    function automatic logic [EW-2:0] quant(input logic [in_width-1:0] mag, input int s);
        int                   p;
        int                   g;
        int                   pm;
        logic [in_width:0]    q;
        logic [MW-1:0]        mv;
        logic [exp_width-1:0] e;
        logic [man_width-1:0] m;
`ifdef MX_QUANT_RNE_EN
        logic [in_width-1:0]  unit;
        logic                 half;
        logic                 sticky;
`endif
        p  = msb_pos(MW'(mag));
        g  = (p - man_width > s) ? (p - man_width) : s;
        q  = {1'b0, mag} >> g;
`ifdef MX_QUANT_RNE_EN
        unit    = '0;
        unit[0] = 1'b1;
        half    = (g > 0) ? |(mag & (unit << (g - 1))) : 1'b0;
        sticky  = (g > 1) ? |(mag & ((unit << (g - 1)) - unit)) : 1'b0;
        q       = q + {{in_width{1'b0}}, half & (sticky | q[0])};
`endif
        // Back to element units; the result is exactly representable unless it overflows.
        mv = MW'(q) << (g - s);
        pm = 0;
        if (mv > MAX_M) begin
            e = '1;
            m = '1;
        end else if (mv < (MW'(1) << man_width)) begin
            e = '0;
            m = mv[man_width-1:0];
        end else begin
            pm = msb_pos(mv);
            e  = exp_width'(pm - man_width + 1);
            m  = man_width'(mv >> (pm - man_width));
        end
        return {e, m};
    endfunction

    // Shared scale from the block maximum: shift just enough to fit W bits.
    always_comb begin
        max_msb    = msb_pos(MW'(max_abs));
        scale_calc = (max_msb > W - 1) ? scl_width'(max_msb - (W - 1)) : '0;
    end

    // Next element to present: element 0 while entering EMIT, otherwise the one after idx.
    always_comb begin
        sel        = (state == CALC) ? '0 : (idx + 1'b1);
        use_scale  = (state == CALC) ? scale_calc : cur_scale;
        sample     = buffer[sel];
        sample_mag = abs_val(sample);
        em         = quant(sample_mag, int'(use_scale));
        // A value that quantizes to zero keeps a clear sign bit so -0 never appears.
        next_elem  = {sample[in_width-1] && (em != '0), em};
    end

    assign in_mag = abs_val(bus.i_data);

    // Sample storage; stale contents after a reset are simply overwritten by the next block.
    always_ff @(posedge clk) begin
        if (state == FILL && bus.i_data_valid) begin
            buffer[cnt] <= bus.i_data;
        end
    end

    // Block sequencing: FILL collects k samples, CALC fixes the scale, EMIT streams elements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            idx       <= '0;
            max_abs   <= '0;
            cur_elem  <= '0;
            cur_scale <= '0;
            cur_valid <= 1'b0;
            cur_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (bus.i_data_valid) begin
                        if (in_mag > max_abs) max_abs <= in_mag;
                        if (cnt == LAST_IDX) begin
                            cnt   <= '0;
                            state <= CALC;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CALC: begin
                    cur_scale <= scale_calc;
                    cur_elem  <= next_elem;
                    cur_valid <= 1'b1;
                    cur_last  <= (k == 1);
                    idx       <= '0;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (bus.i_elem_ready) begin
                        if (cur_last) begin
                            cur_valid <= 1'b0;
                            cur_last  <= 1'b0;
                            idx       <= '0;
                            max_abs   <= '0;
                            state     <= FILL;
                        end else begin
                            idx      <= idx + 1'b1;
                            cur_elem <= next_elem;
                            cur_last <= ((idx + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    assign bus.o_data_ready = (state == FILL);
    assign bus.o_elem       = cur_elem;
    assign bus.o_scale      = cur_scale;
    assign bus.o_elem_valid = cur_valid;
    assign bus.o_last       = cur_last;
endmodule

// File: tb/tb_mx_quant_stream.sv
// Bench for mx_quant_stream: table of hand-derived blocks, random-stall blocks and reset sequences.
// Every consumed element is checked against an independent nearest-code search model.
module tb_mx_quant_stream;
    logic clk;
    logic rst;

    mx_quant_stream_if #(.in_width(24), .exp_width(4), .man_width(3), .scl_width(8)) bus ();

    mx_quant_stream #(
        .in_width(24), .exp_width(4), .man_width(3), .k(32), .scl_width(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MX_QUANT_RNE_EN
    localparam logic [7:0] X31   = 8'h18;
    localparam logic [7:0] X19   = 8'h12;
    localparam logic [7:0] X12S3 = 8'h02;
`else
    localparam logic [7:0] X31   = 8'h17;
    localparam logic [7:0] X19   = 8'h11;
    localparam logic [7:0] X12S3 = 8'h01;
`endif

    typedef struct {
        bit          ramp;
        logic [23:0] e0, e1, e2, rest;
        int          i0, i1, i2;
        logic [7:0]  c0, c1, c2, scl;
    } vec_t;

    typedef struct {
        logic [7:0] elem;
        logic [7:0] scale;
        logic       last;
    } exp_t;

    vec_t        tbl [8];
    exp_t        sb [$];
    logic [7:0]  cap_elem [$];
    logic [7:0]  cap_scale [$];
    logic [23:0] blk [32];
    int          errors = 0;
    int          checks = 0;
    int          rdy_mode = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic longint mag_of(input logic [23:0] v);
        return v[23] ? (longint'(16777216) - longint'(v)) : longint'(v);
    endfunction

    function automatic int ref_scale(input logic [23:0] vals [32]);
        longint mx;
        int     p;
        mx = 0;
        for (int i = 0; i < 32; i++) if (mag_of(vals[i]) > mx) mx = mag_of(vals[i]);
        p = 0;
        for (int b = 0; b < 40; b++) if (mx[b]) p = b;
        return (p > 17) ? p - 17 : 0;
    endfunction

    // Exhaustive search over all 128 magnitude codes.
    function automatic logic [7:0] ref_code(input logic [23:0] v, input int s);
        longint a, val;
        int     best, mm;
`ifdef MX_QUANT_RNE_EN
        longint d, bd;
`endif
        a    = mag_of(v);
        best = 0;
`ifdef MX_QUANT_RNE_EN
        bd = a;
`endif
        for (int c = 0; c < 128; c++) begin
            mm  = (c < 8) ? c : ((8 + (c & 7)) << ((c >> 3) - 1));
            val = longint'(mm) << s;
`ifdef MX_QUANT_RNE_EN
            d = (val > a) ? val - a : a - val;
            if (d < bd || (d == bd && (c & 1) == 0)) begin
                best = c;
                bd   = d;
            end
`else
            if (val <= a) best = c;
`endif
        end
        if (v[23] && best != 0) return {1'b1, 7'(best)};
        return {1'b0, 7'(best)};
    endfunction

    task automatic send_one(input logic [23:0] v, input bit gaps);
        bit acc;
        int n;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            bus.i_data_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.i_data       = v;
        bus.i_data_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 400) begin
            @(negedge clk);
            acc = bus.o_data_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.i_data_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL input_handshake: o_data_ready stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic send_block(input logic [23:0] vals [32], input bit gaps);
        int   s;
        exp_t e;
        for (int i = 0; i < 32; i++) send_one(vals[i], gaps);
        s = ref_scale(vals);
        for (int i = 0; i < 32; i++) begin
            e.elem  = ref_code(vals[i], s);
            e.scale = 8'(s);
            e.last  = (i == 31);
            sb.push_back(e);
        end
        check("calc_elem_valid", bus.o_elem_valid, 0);
        check("calc_data_ready", bus.o_data_ready, 0);
        @(posedge clk); #1;
        check("emit_elem_valid", bus.o_elem_valid, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.o_elem_valid) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d elements outstanding, required 0", sb.size());
        end
    endtask

    // Downstream ready: always 1, random, or held 0.
    initial begin
        bus.i_elem_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       bus.i_elem_ready = 1'($urandom_range(0, 1));
                2:       bus.i_elem_ready = 1'b0;
                default: bus.i_elem_ready = 1'b1;
            endcase
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        bit         prev_stall;
        logic [7:0] pe, ps;
        logic       pl;
        exp_t       e;
        prev_stall = 1'b0;
        pe = '0; ps = '0; pl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", bus.o_elem_valid, 1);
                    check("stall_elem", bus.o_elem, pe);
                    check("stall_scale", bus.o_scale, ps);
                    check("stall_last", bus.o_last, pl);
                end
                if (bus.o_elem_valid) begin
                    check("emit_data_ready", bus.o_data_ready, 0);
                    if (bus.i_elem_ready) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_elem: got %h with no element outstanding", bus.o_elem);
                        end else begin
                            e = sb.pop_front();
                            check("sb_elem", bus.o_elem, e.elem);
                            check("sb_scale", bus.o_scale, e.scale);
                            check("sb_last", bus.o_last, e.last);
                        end
                        cap_elem.push_back(bus.o_elem);
                        cap_scale.push_back(bus.o_scale);
                    end
                end
                prev_stall = bus.o_elem_valid && !bus.i_elem_ready;
                pe = bus.o_elem;
                ps = bus.o_scale;
                pl = bus.o_last;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [23:0] x;

        tbl[0] = '{1'b1, 24'h0, 24'h0, 24'h0, 24'h0, 5, 12, 31, 8'h05, 8'h0C, X31, 8'h00};
        tbl[1] = '{1'b0, 24'd19, 24'd17, 24'hFFFFF4, 24'h0, 0, 1, 2, X19, 8'h10, 8'h8C, 8'h00};
        tbl[2] = '{1'b0, 24'h100000, 24'd1, 24'd1, 24'd1, 0, 1, 2, 8'h78, 8'h00, 8'h00, 8'h03};
        tbl[3] = '{1'b0, 24'h03FFFF, 24'h0, 24'h0, 24'h0, 0, 1, 2, 8'h7F, 8'h00, 8'h00, 8'h00};
        tbl[4] = '{1'b0, 24'h800000, 24'h0, 24'h0, 24'h0, 0, 1, 2, 8'hF8, 8'h00, 8'h00, 8'h06};
        tbl[5] = '{1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 0, 1, 2, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[6] = '{1'b0, 24'hFFFFFF, 24'd7, 24'd8, 24'h0, 0, 1, 2, 8'h81, 8'h07, 8'h08, 8'h00};
        tbl[7] = '{1'b0, 24'h100000, 24'd12, 24'd4, 24'h0, 0, 1, 2, 8'h78, X12S3, 8'h00, 8'h03};

        rst              = 1'b1;
        bus.i_data       = '0;
        bus.i_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_elem_valid", bus.o_elem_valid, 0);
        check("rst_last", bus.o_last, 0);
        check("rst_elem", bus.o_elem, 0);
        check("rst_scale", bus.o_scale, 0);
        check("rst_data_ready", bus.o_data_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) begin
                if (tbl[r].ramp)  blk[i] = 24'(i);
                else if (i == 0)  blk[i] = tbl[r].e0;
                else if (i == 1)  blk[i] = tbl[r].e1;
                else if (i == 2)  blk[i] = tbl[r].e2;
                else              blk[i] = tbl[r].rest;
            end
            cap_elem.delete();
            cap_scale.delete();
            send_block(blk, r[0]);
            n = 0;
            while (cap_elem.size() < 32 && n < 500) begin
                @(posedge clk); #1;
                n++;
            end
            if (cap_elem.size() < 32) begin
                checks++;
                errors++;
                $display("FAIL r%0d_count: got %0d elements, required 32", r, cap_elem.size());
            end else begin
                check($sformatf("r%0d_scale", r), cap_scale[0], tbl[r].scl);
                check($sformatf("r%0d_c0", r), cap_elem[tbl[r].i0], tbl[r].c0);
                check($sformatf("r%0d_c1", r), cap_elem[tbl[r].i1], tbl[r].c1);
                check($sformatf("r%0d_c2", r), cap_elem[tbl[r].i2], tbl[r].c2);
            end
            wait_drain();
        end

        // Three back-to-back random blocks under random downstream stalls.
        rdy_mode = 1;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 32; i++) begin
                x      = 24'($urandom);
                blk[i] = 24'($signed(x) >>> $urandom_range(0, 22));
            end
            send_block(blk, 1'b1);
        end
        wait_drain();
        rdy_mode = 0;

        // Reset after 10 samples of a large-valued block; the next block must stand alone.
        for (int i = 0; i < 10; i++) send_one(24'h7FFFFF, 1'b0);
        rst = 1'b1;
        #1;
        check("midfill_rst_valid", bus.o_elem_valid, 0);
        check("midfill_rst_ready", bus.o_data_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) blk[i] = 24'(i);
        cap_scale.delete();
        cap_elem.delete();
        send_block(blk, 1'b0);
        wait_drain();
        check("midfill_scale", cap_scale[0], 0);

        // Reset while elements are stalled in EMIT.
        rdy_mode = 2;
        for (int i = 0; i < 32; i++) blk[i] = (i == 0) ? 24'h100000 : 24'd1;
        send_block(blk, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midemit_rst_valid", bus.o_elem_valid, 0);
        check("midemit_rst_ready", bus.o_data_ready, 1);
        sb.delete();
        @(negedge clk);
        rst      = 1'b0;
        rdy_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) blk[i] = (i == 5) ? 24'hFFFFF4 : 24'd3;
        send_block(blk, 1'b1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
